mdiv: RTL and testbench

Iterative RV32M divide/remainder unit for DIV, DIVU, REM and REMU. It sits in the execute stage beside the combinational multiply ALU. The pipeline stalls on `busy_o` while the unit runs. The core is a radix-2 restoring divider on operand magnitudes. Sign and RISC-V special-case fix-ups are applied before the result is registered.

---
 rtl/mdiv.sv | 141 ++++++++++++++
 tb/tb_mdiv.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdiv.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider on magnitudes.
// Define MDIV_EARLY_OUT_EN to resolve divide-by-zero and signed overflow at acceptance.
module mdiv #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] data0_i,
   input  logic [XLEN-1:0] data1_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] data_o
);

`ifdef MDIV_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   logic [4:0]      count;
   logic [1:0]      op_q;
   logic            neg_a_q, neg_b_q, div_zero_q, ovf_q;
   logic [XLEN-1:0] dividend_q, divisor_q, quo_q, rem_q, res_q;

   // op_i[0] = unsigned, op_i[1] = remainder
   logic            signed_in, a_neg_in, b_neg_in, zero_in, ovf_in, early_in;
   logic [XLEN-1:0] a_mag_in, b_mag_in, special_in;

   assign signed_in = ~op_i[0];
   assign a_neg_in  = signed_in & data0_i[XLEN-1];
   assign b_neg_in  = signed_in & data1_i[XLEN-1];
   assign a_mag_in  = a_neg_in ? -data0_i : data0_i;
   assign b_mag_in  = b_neg_in ? -data1_i : data1_i;
   assign zero_in   = (data1_i == '0);
   assign ovf_in    = signed_in && (data0_i == {1'b1, {(XLEN-1){1'b0}}}) && (data1_i == '1);
   assign early_in  = zero_in | ovf_in;
   assign special_in = op_i[1] ? (zero_in ? data0_i : '0)
                               : (zero_in ? '1 : {1'b1, {(XLEN-1){1'b0}}});

   // One restoring step: the shifted value can need XLEN+1 bits, but the
   // kept remainder is always below the divisor and fits in XLEN bits.
   logic [XLEN:0]   shift_rem;
   logic            ge;
   logic [XLEN-1:0] trial;

   assign shift_rem = {rem_q, quo_q[XLEN-1]};
   assign ge        = (shift_rem >= {1'b0, divisor_q});
   assign trial     = shift_rem[XLEN-1:0] - divisor_q;

   logic [XLEN-1:0] q_fix, r_fix, fix_res;

   assign q_fix = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
   assign r_fix = neg_a_q ? -rem_q : rem_q;

   // NOTE: fix_res is assigned first on every pass, so no latch is inferred.
   always_comb begin
      fix_res = op_q[1] ? r_fix : q_fix;
      if (div_zero_q)
         fix_res = op_q[1] ? dividend_q : '1;
      else if (ovf_q)
         fix_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // NOTE: all registers update with <= so each one samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         count      <= '0;
         op_q       <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         res_q      <= '0;
         busy_o     <= 1'b0;
         valid_o    <= 1'b0;
         data_o     <= '0;
      end else if (flush_i) begin
         state   <= IDLE;
         busy_o  <= 1'b0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  op_q       <= op_i;
                  neg_a_q    <= a_neg_in;
                  neg_b_q    <= b_neg_in;
                  div_zero_q <= zero_in;
                  ovf_q      <= ovf_in;
                  dividend_q <= data0_i;
                  quo_q      <= a_mag_in;
                  divisor_q  <= b_mag_in;
                  rem_q      <= '0;
                  count      <= 5'd31;
                  busy_o     <= 1'b1;
                  if (EARLY_OUT && early_in) begin
                     res_q <= special_in;
                     state <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= ge ? trial : shift_rem[XLEN-1:0];
               quo_q <= {quo_q[XLEN-2:0], ge};
               if (count == 5'd0)
                  state <= FIX;
               else
                  count <= count - 5'd1;
            end
            FIX: begin
               res_q <= fix_res;
               state <= DONE;
            end
            DONE: begin
               // Result becomes visible together with the valid pulse.
               data_o  <= res_q;
               valid_o <= 1'b1;
               busy_o  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdiv.sv
// Self-checking bench for mdiv: directed RV32M cases, random operations against
// an arithmetic reference model, flush, ignored start, back-to-back and async reset.
module tb_mdiv;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  op_i = '0;
   logic [31:0] data0_i = '0;
   logic [31:0] data1_i = '0;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] data_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] last_exp = '0;

   mdiv #(.XLEN(32)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .flush_i (flush_i),
      .op_i    (op_i),
      .data0_i (data0_i),
      .data1_i (data1_i),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .data_o  (data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // RISC-V M semantics expressed with plain SystemVerilog arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_DIV: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'($signed(a) / $signed(b));
         end
         OP_REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         OP_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDIV_EARLY_OUT_EN
      if (is_special(op, a, b)) return 1;
`else
      if (is_special(op, a, b)) return 34;
`endif
      return 34;
   endfunction

   // Called just after a falling edge; returns 1 ns after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      op_i    = op;
      data0_i = a;
      data1_i = b;
      start_i = 1'b1;
      @(posedge clk_i);
      #1 start_i = 1'b0;
   endtask

   // Counts falling edges until valid_o; busy_o must be high on each one before it.
   task automatic await_result(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int lat);
      logic [31:0] exp;
      int          k;
      int          busy_cnt;
      bit          seen;
      exp = ref_result(op, a, b);
      k = 0;
      busy_cnt = 0;
      seen = 1'b0;
      while (!seen && k < 100) begin
         @(negedge clk_i);
         if (valid_o) seen = 1'b1;
         else begin
            if (busy_o) busy_cnt++;
            k++;
         end
      end
      check({tag, ".latency"}, 32'(k), 32'(lat));
      check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(lat));
      check({tag, ".data"}, data_o, exp);
      last_exp = exp;
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk_i);
      issue(op, a, b);
      await_result(tag, op, a, b, lat_of(op, a, b));
      @(negedge clk_i);
      check({tag, ".pulse"}, {31'h0, valid_o}, 32'h0);
      check({tag, ".hold"}, data_o, last_exp);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          vcount;

      // Reset state
      #12;
      check("rst.busy", {31'h0, busy_o}, 32'h0);
      check("rst.valid", {31'h0, valid_o}, 32'h0);
      check("rst.data", data_o, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Directed cases
      run_op("div_neg7_2",  OP_DIV,  32'hFFFF_FFF9, 32'h2);
      run_op("rem_neg7_2",  OP_REM,  32'hFFFF_FFF9, 32'h2);
      run_op("divu_max_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10);
      run_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'h10);
      run_op("div_by0",     OP_DIV,  32'h1234_5678, 32'h0);
      run_op("rem_by0",     OP_REM,  32'h1234_5678, 32'h0);
      run_op("divu_by0",    OP_DIVU, 32'h8765_4321, 32'h0);
      run_op("remu_by0",    OP_REMU, 32'h8765_4321, 32'h0);
      run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_ovfpat", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div_negneg",  OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9);

      // Random operations with biased divisors
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), op, a, b);
      end

      // Back-to-back: second start raised in the valid cycle of the first
      @(negedge clk_i);
      issue(OP_DIVU, 32'd1000, 32'd3);
      await_result("b2b_first", OP_DIVU, 32'd1000, 32'd3, 34);
      issue(OP_REM, 32'hFFFF_FC18, 32'd7);
      await_result("b2b_second", OP_REM, 32'hFFFF_FC18, 32'd7, 34);

      // A start raised while busy is ignored and never produces a second result
      @(negedge clk_i);
      issue(OP_DIVU, 32'd5000, 32'd9);
      repeat (3) @(negedge clk_i);
      op_i = OP_REMU;
      data0_i = 32'd77;
      data1_i = 32'd5;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      await_result("ignored_start", OP_DIVU, 32'd5000, 32'd9, 30);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (valid_o) vcount++;
      end
      check("ignored_start.no_extra", 32'(vcount), 32'h0);

      // Flush mid-CALC: no valid, result register untouched
      @(negedge clk_i);
      issue(OP_DIV, 32'h7FFF_0001, 32'd13);
      repeat (10) @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush.busy", {31'h0, busy_o}, 32'h0);
      vcount = 0;
      repeat (2) begin
         @(negedge clk_i);
         if (valid_o) vcount++;
      end
      check("flush.no_valid", 32'(vcount), 32'h0);
      check("flush.data_kept", data_o, last_exp);
      issue(OP_REMU, 32'hDEAD_BEEF, 32'd1000);
      await_result("after_flush", OP_REMU, 32'hDEAD_BEEF, 32'd1000, 34);

      // Asynchronous reset mid-CALC clears outputs without a clock edge
      @(negedge clk_i);
      issue(OP_DIVU, 32'hFFFF_0000, 32'd3);
      repeat (15) @(negedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check("arst.busy", {31'h0, busy_o}, 32'h0);
      check("arst.valid", {31'h0, valid_o}, 32'h0);
      check("arst.data", data_o, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      run_op("after_rst", OP_DIVU, 32'd100, 32'd7);
      check("after_rst.is14", last_exp, 32'd14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
